// File: rtl/m_dm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : m_dm_pkg
// Purpose  : Shared pipeline definitions for the data memory: store/load op
//            encodings, data-memory FSM states and an alignment helper.
// Revision : 1.0 - initial release
// ============================================================================
package m_dm_pkg;

  typedef enum logic [1:0] {
    ST_NONE = 2'b00,
    ST_SB   = 2'b01,
    ST_SH   = 2'b10,
    ST_SW   = 2'b11
  } store_op_e;

  typedef enum logic [2:0] {
    LD_NONE = 3'b000,
    LD_LW   = 3'b001,
    LD_LB   = 3'b010,
    LD_LBU  = 3'b011,
    LD_LH   = 3'b100,
    LD_LHU  = 3'b101
  } load_op_e;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } dm_state_e;

  // Word ops need both low bits clear, halfword ops need bit 0 clear,
  // byte ops never fault.
  function automatic logic f_misaligned(input logic [1:0] off,
                                        input logic       is_word,
                                        input logic       is_half);
    return (is_word && (off != 2'b00)) || (is_half && off[0]);
  endfunction

endpackage
`default_nettype wire

// File: rtl/m_dm_if.sv
`default_nettype none
// ============================================================================
// Module   : m_dm_if
// Purpose  : M-stage data-memory bus.
//   in_pc/in_addr/in_wdata/in_store_op/in_load_op : request from the pipeline
//   out_dm_out    : extended load result
//   out_busy      : memory is clearing
//   out_align_err : current access misaligned
//   out_wr_en/out_wr_pc/out_wr_addr/out_wr_data : committed-store trace tap
//                   (word-aligned address and full merged word)
// Revision : 1.0 - initial release
// ============================================================================
interface m_dm_if;
  logic [31:0] in_pc;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic [1:0]  in_store_op;
  logic [2:0]  in_load_op;
  logic [31:0] out_dm_out;
  logic        out_busy;
  logic        out_align_err;
  logic        out_wr_en;
  logic [31:0] out_wr_pc;
  logic [31:0] out_wr_addr;
  logic [31:0] out_wr_data;

  modport master (
    output in_pc, in_addr, in_wdata, in_store_op, in_load_op,
    input  out_dm_out, out_busy, out_align_err,
           out_wr_en, out_wr_pc, out_wr_addr, out_wr_data
  );

  modport slave (
    input  in_pc, in_addr, in_wdata, in_store_op, in_load_op,
    output out_dm_out, out_busy, out_align_err,
           out_wr_en, out_wr_pc, out_wr_addr, out_wr_data
  );
endinterface
`default_nettype wire

// File: rtl/m_dm_ext.sv
`default_nettype none
// ============================================================================
// Module   : dm_ext
// Purpose  : Combinational byte-lane unit. Merges store data into an existing
//            word and extracts/extends load data from the same word.
//   i_word     : current word from the array
//   i_off      : byte offset in_addr[1:0]
//   i_wdata    : store data
//   i_store_op : store type
//   i_load_op  : load type
//   o_merged   : word after applying the store
//   o_load     : extended load result (0 for no/unknown load op)
// Revision : 1.0 - initial release
// ============================================================================
module dm_ext
  import m_dm_pkg::*;
(
  input  wire logic [31:0] i_word,
  input  wire logic [1:0]  i_off,
  input  wire logic [31:0] i_wdata,
  input  wire logic [1:0]  i_store_op,
  input  wire logic [2:0]  i_load_op,
  output logic      [31:0] o_merged,
  output logic      [31:0] o_load
);

  logic [31:0] w_shifted;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_shifted = i_word >> {i_off, 3'b000};
  assign w_byte    = w_shifted[7:0];
  assign w_half    = i_off[1] ? i_word[31:16] : i_word[15:0];

  always_comb begin
    o_merged = i_word;
    case (i_store_op)
      ST_SB: begin
        case (i_off)
          2'd0:    o_merged[7:0]   = i_wdata[7:0];
          2'd1:    o_merged[15:8]  = i_wdata[7:0];
          2'd2:    o_merged[23:16] = i_wdata[7:0];
          default: o_merged[31:24] = i_wdata[7:0];
        endcase
      end
      ST_SH: begin
        if (i_off[1]) o_merged[31:16] = i_wdata[15:0];
        else          o_merged[15:0]  = i_wdata[15:0];
      end
      ST_SW:   o_merged = i_wdata;
      default: o_merged = i_word;
    endcase
  end

  always_comb begin
    o_load = 32'h0;
    case (i_load_op)
      LD_LW:   o_load = i_word;
      LD_LB:   o_load = {{24{w_byte[7]}}, w_byte};
      LD_LBU:  o_load = {24'h0, w_byte};
      LD_LH:   o_load = {{16{w_half[15]}}, w_half};
      LD_LHU:  o_load = {16'h0, w_half};
      default: o_load = 32'h0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/m_dm.sv
`default_nettype none
// ============================================================================
// Module   : m_dm
// Purpose  : M-stage data memory with a self-clearing FSM. After reset every
//            word is zeroed one per cycle (out_busy high), then the array
//            serves combinational loads and synchronous stores.
//   clk   : system clock (rising edge)
//   reset : asynchronous active-low reset
//   bus   : m_dm_if.slave request/response bus
// Revision : 1.0 - initial release
// ============================================================================
module m_dm
  import m_dm_pkg::*;
#(
  parameter int DEPTH = 3072,
  parameter int AW    = 12
)(
  input  wire logic clk,
  input  wire logic reset,
  m_dm_if.slave     bus
);

  dm_state_e     r_state;
  logic [AW-1:0] r_cnt;
  logic [31:0]   r_mem [DEPTH];

  logic [AW-1:0] w_idx;
  logic [1:0]    w_off;
  logic          w_in_range;
  logic          w_st_mis;
  logic          w_ld_mis;
  logic          w_ready;
  logic          w_commit;
  logic [31:0]   w_rd_word;
  logic [31:0]   w_merged;
  logic [31:0]   w_load;

  assign w_idx      = bus.in_addr[AW+1:2];
  assign w_off      = bus.in_addr[1:0];
  assign w_in_range = (32'(w_idx) < 32'(DEPTH));
  assign w_ready    = (r_state == S_READY);

  assign w_st_mis = f_misaligned(w_off, bus.in_store_op == ST_SW,
                                 bus.in_store_op == ST_SH);
  assign w_ld_mis = f_misaligned(w_off, bus.in_load_op == LD_LW,
                                 (bus.in_load_op == LD_LH) ||
                                 (bus.in_load_op == LD_LHU));

  // Out-of-range indices read as zero rather than aliasing into the array.
  assign w_rd_word = w_in_range ? r_mem[w_idx] : 32'h0;

  dm_ext u_ext (
    .i_word     (w_rd_word),
    .i_off      (w_off),
    .i_wdata    (bus.in_wdata),
    .i_store_op (bus.in_store_op),
    .i_load_op  (bus.in_load_op),
    .o_merged   (w_merged),
    .o_load     (w_load)
  );

  assign w_commit = w_ready && (bus.in_store_op != ST_NONE) &&
                    !w_st_mis && w_in_range;

  assign bus.out_busy      = !w_ready;
  assign bus.out_align_err = w_st_mis || w_ld_mis;
  // Load reads the array before this cycle's store lands, giving
  // pre-store data when both hit the same word.
  assign bus.out_dm_out    = (w_ready && !w_ld_mis) ? w_load : 32'h0;

  assign bus.out_wr_en   = w_commit;
  assign bus.out_wr_pc   = bus.in_pc;
  assign bus.out_wr_addr = {bus.in_addr[31:2], 2'b00};
  assign bus.out_wr_data = w_merged;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_CLEAR;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == AW'(DEPTH - 1)) r_state <= S_READY;
        end
        default: r_state <= S_READY;
      endcase
    end
  end

  // Array has no reset; the clear sequence is the only zeroing path.
  always_ff @(posedge clk) begin
    if (r_state == S_CLEAR) begin
      r_mem[r_cnt] <= 32'h0;
    end else if (w_commit) begin
      r_mem[w_idx] <= w_merged;
    end
  end

endmodule
`default_nettype wire

// File: doc/m_dm.md
M_DM -- requirements
Module: m_dm

Interface
REQ-001 The block SHALL have parameter DEPTH, default 3072, meaning the number of 32-bit data-memory words.
REQ-002 The block SHALL have parameter AW, default 12, meaning the word-index width, with ceil(log2(DEPTH)) <= AW.
REQ-003 clk  input  1  the single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 in_pc  input  32  PC of the instruction in M, used only for the write trace.
REQ-006 in_addr  input  32  byte address, the ALU result from M.
REQ-007 in_wdata  input  32  store data, the forwarded rt value.
REQ-008 in_store_op  input  2  store type: 00 none, 01 sb, 10 sh, 11 sw.
REQ-009 in_load_op  input  3  load type: 000 none, 001 lw, 010 lb, 011 lbu, 100 lh, 101 lhu.
REQ-010 out_dm_out  output  32  extended load result, feeding the W pipeline register dm_out input.
REQ-011 out_busy  output  1  memory is clearing; the hazard unit stalls F/D/E and bubbles M.
REQ-012 out_align_err  output  1  the current access is misaligned.

Function
REQ-020 The FSM SHALL have two states, CLEAR and READY; reset forces CLEAR with the clear counter at 0.
REQ-021 In CLEAR, one word SHALL be written to 0 per cycle at index=counter, and the counter SHALL increment.
REQ-022 The transition CLEAR->READY SHALL occur on the edge that writes index DEPTH-1; READY has no exit except reset.
REQ-023 out_busy SHALL be 1 exactly while in CLEAR: DEPTH cycles after reset release.
REQ-024 The word index SHALL be in_addr[AW+1:2]; addresses with index >= DEPTH SHALL not write and SHALL read 0.
REQ-025 Alignment rules: sw/lw require in_addr[1:0]==00; sh/lh/lhu require in_addr[0]==0; byte ops are always aligned.
REQ-026 out_align_err SHALL be combinational and SHALL be 0 when both the store op and the load op are none.
REQ-027 Stores SHALL write synchronously in READY, and only when aligned and in range.
REQ-028 sb SHALL replace byte in_addr[1:0] with in_wdata[7:0].
REQ-029 sh SHALL replace halfword in_addr[1] with in_wdata[15:0]; untouched bytes are preserved.
REQ-030 Loads SHALL be combinational from the current array contents, with zero latency in M.
REQ-031 Load extension: lb/lh sign-extend, lbu/lhu zero-extend, lw passes the word unchanged.
REQ-032 out_dm_out SHALL be 0 for load none, on a misaligned load, and whenever out_busy=1.
REQ-033 A store and a load in the same cycle to the same word SHALL return the pre-store data, with the store visible next cycle.
REQ-034 Stores presented during CLEAR SHALL be ignored (the upstream stall guarantees none are issued).
REQ-035 Each committed store SHALL emit the simulation trace "@<pc>: *<word-aligned addr> <= <full merged word>" in hex.

Reset
REQ-040 Asserting reset SHALL immediately set the state to CLEAR, the counter to 0 and out_busy to 1, and force out_dm_out to 0.
REQ-041 Reset asserted mid-CLEAR SHALL restart the clear at index 0.
REQ-042 Reset asserted in READY SHALL discard all memory contents, which the clear sequence zeroes.
REQ-043 The array itself SHALL not be reset asynchronously; zeroing is by the clear FSM only.

Structure
REQ-050 Store/load op encodings and the FSM state encoding SHALL reside in the shared pipeline definitions package.
REQ-051 Byte-lane merge and load extension SHALL be one combinational sub-module, dm_ext, reused for the store merge and the load path.
REQ-052 The array, counter and FSM SHALL reside in m_dm; no other state is permitted.

Verification
REQ-060 Release reset -> out_busy=1 for exactly DEPTH cycles then 0; a lw of any address then returns 0.
REQ-061 sw 0x12345678 @0x0 then sb 0xAB @0x1 -> lw @0x0 = 0x1234AB78, trace "*00000000 <= 1234ab78".
REQ-062 Word 0x0000F080 @0x4 -> lb @0x4 = 0xFFFFFF80; lbu @0x4 = 0x00000080; lh @0x4 = 0xFFFFF080; lhu @0x4 = 0x0000F080.
REQ-063 sw @0x2 and lh @0x3 -> out_align_err=1, memory unchanged, out_dm_out=0.
REQ-064 Assert reset at clear index 100, release -> out_busy high for a full DEPTH cycles again.
REQ-065 Same-cycle sw 0x5 and lw @0x8 (old value 0) -> out_dm_out=0 that cycle, 0x5 next cycle.
